// File: rtl/regwrite_trace_buffer_pkg.sv
// Shared widths and the trace-entry layout for the register-writeback trace buffer.
package regwrite_trace_buffer_pkg;

  localparam int unsigned TRACE_REG_W   = 5;
  localparam int unsigned TRACE_DATA_W  = 32;
  localparam int unsigned TRACE_CYCLE_W = 16;
  localparam int unsigned DROP_CNT_W    = 8;

  typedef struct packed {
    logic [TRACE_CYCLE_W-1:0] cycle;
    logic [TRACE_REG_W-1:0]   rd;
    logic [TRACE_DATA_W-1:0]  data;
  } trace_entry_t;

endpackage

// File: rtl/regwrite_trace_buffer_trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO; the head entry is always on rdata.
module trace_fifo #(
  parameter int unsigned WIDTH = 53,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regwrite_trace_buffer.sv
// Records qualifying register-file writebacks with a cycle stamp into a FWFT trace FIFO.
module regwrite_trace_buffer
  import regwrite_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CYCLE_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic                     ctrl_writeEnable,
  input  logic [TRACE_REG_W-1:0]   ctrl_writeReg,
  input  logic [TRACE_DATA_W-1:0]  data_writeReg,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CYCLE_W-1:0]       out_cycle,
  output logic [TRACE_REG_W-1:0]   out_reg,
  output logic [TRACE_DATA_W-1:0]  out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_CNT_W-1:0]    drop_count
);

  localparam int unsigned ENTRY_W = CYCLE_W + TRACE_REG_W + TRACE_DATA_W;

  logic [CYCLE_W-1:0] cycle_cnt;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;
  logic               qual;
  logic               pop;
  logic               full;
  logic               empty;
  logic               drop;

  assign qual      = capture_en & ctrl_writeEnable & (ctrl_writeReg != '0);
  assign pop       = out_valid & out_ready;
  assign drop      = qual & full & ~pop;
  assign wdata     = {cycle_cnt, ctrl_writeReg, data_writeReg};
  assign out_valid = ~empty;
  assign {out_cycle, out_reg, out_data} = rdata;

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (qual),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Free-running stamp; the first cycle after reset is stamp 0.
  always_ff @(posedge clock) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + CYCLE_W'(1);
  end

  // Overflow is sticky until reset; the drop counter saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end

endmodule

// File: doc/regwrite_trace_buffer.md
REGWRITE_TRACE_BUFFER -- requirements
Module: regwrite_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, meaning FIFO entry count; SHALL be a power of two, 2..256.
REQ-002 Parameter CYCLE_W, default 16, meaning cycle-stamp width.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 capture_en  input  1  1 = record writebacks; 0 = ignore them (harness test mode).
REQ-006 ctrl_writeEnable  input  1  processor regfile write strobe.
REQ-007 ctrl_writeReg  input  5  destination register.
REQ-008 data_writeReg  input  32  writeback data.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  consumer accepts the head entry.
REQ-011 out_cycle  output  CYCLE_W  cycle stamp of the head entry.
REQ-012 out_reg  output  5  register of the head entry.
REQ-013 out_data  output  32  data of the head entry.
REQ-014 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-015 overflow  output  1  sticky; set when a qualifying write is dropped.
REQ-016 drop_count  output  8  number of dropped writes, saturating at 255.

Function
REQ-017 Free-running cycle counter SHALL increment by 1 every clock and wrap from 2^CYCLE_W-1 to 0.
REQ-018 A write qualifies when capture_en=1, ctrl_writeEnable=1 and ctrl_writeReg!=0.
REQ-019 A qualifying write SHALL be pushed as {cycle counter value in that cycle, ctrl_writeReg, data_writeReg}.
REQ-020 The first clock after reset SHALL be stamped 0.
REQ-021 Pop occurs when out_valid=1 and out_ready=1.
REQ-022 out_valid SHALL equal (count!=0).
REQ-023 The out_* fields SHALL be driven from the head entry (first-word-fall-through).
REQ-024 A pushed entry SHALL be visible on out_* one cycle after the push edge.
REQ-025 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Full (count=DEPTH) with a qualifying write and no pop: write dropped, overflow set to 1, drop_count incremented.
REQ-027 Full with a qualifying write and a pop in the same cycle: the push SHALL be accepted, count stays DEPTH, no drop.
REQ-028 Empty with a qualifying write: out_valid=0 in that cycle; there is no bypass.
REQ-029 Simultaneous push and pop when not empty and not full: count unchanged.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 When out_valid=0, out_* values are don't-care; the bench SHALL NOT check them.
REQ-032 overflow SHALL clear only on reset.

Reset
REQ-033 In the cycle after reset=1 is sampled:
- count=0, out_valid=0, overflow=0, drop_count=0
- pointers=0, cycle counter=0
REQ-034 Reset asserted mid-operation SHALL discard all buffered entries.
REQ-035 Writes presented in a reset cycle SHALL NOT be recorded.
REQ-036 Storage array contents need no reset.

Structure
REQ-037 The shared package SHALL hold:
- TRACE_REG_W=5 and TRACE_DATA_W=32
- the packed trace-entry typedef {cycle, reg, data}
- DROP_CNT_W=8
REQ-038 One sub-module, trace_fifo: a generic synchronous FWFT FIFO, parameterised by width and depth, reporting count and full/empty.
REQ-039 Qualification, cycle stamping and overflow accounting SHALL live in the top module.

Verification
REQ-040 Reset, then rd=3, data=0xDEADBEEF, write at stamp 5, out_ready=0 -> from the next cycle, out_valid=1, out_cycle=5, out_reg=3, out_data=0xDEADBEEF; count=1; held stable.
REQ-041 Write with rd=0, and a write with capture_en=0 -> count stays 0, out_valid stays 0.
REQ-042 17 consecutive qualifying writes with DEPTH=16 and out_ready=0:
- count=16, overflow=1, drop_count=1
- draining gives the first 16 in order
REQ-043 Full FIFO, push and pop in the same cycle -> count=16, no drop, oldest entry removed, newest appended.
REQ-044 Reset asserted with count=7 -> next cycle count=0, out_valid=0, overflow=0, and the stamp restarts at 0.
REQ-045 Run 65540 cycles with CYCLE_W=16 -> a write on cycle 65537 after reset is stamped 1 (wrap).
